// File: rtl/cpu_defs.sv
// Shared CPU definitions: memory opcodes, MEM-stage state encoding and opcode classifiers.
package cpu_defs;

   localparam logic [5:0] OP_NOP = 6'h00;
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_WAIT = 2'd1,
      MS_DONE = 2'd2
   } ms_state_t;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SW) || (op == OP_SB);
   endfunction

   // Only word accesses carry an alignment constraint; byte accesses never fault.
   function automatic logic is_word_op(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/load_align.sv
// Byte lane select and extension of a 32-bit memory word for byte loads.
module load_align (
   input  logic [31:0] rdata,
   input  logic [1:0]  a,
   input  logic        sign,
   output logic [31:0] result
);

   logic [7:0] lane;

   always_comb begin
      case (a)
         2'd0:    lane = rdata[7:0];
         2'd1:    lane = rdata[15:8];
         2'd2:    lane = rdata[23:16];
         default: lane = rdata[31:24];
      endcase
      result = {{24{sign & lane[7]}}, lane};
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives loads/stores onto a req/ack data port, stalls upstream while busy.
//
// state   | meaning
// IDLE    | no access outstanding; pass-through, launch, or drop misaligned/aborted op
// WAIT    | request held, counting toward timeout
// DONE    | access complete; emit result to MEM_WB
module mem_stage
   import cpu_defs::*;
#(
   parameter int         TIMEOUT = 16,
   parameter logic [5:0] NOP_OP  = OP_NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  op_ex,
   input  logic        ife_ex,
   input  logic [4:0]  Ri_ex,
   input  logic [31:0] alu_ex,
   input  logic [31:0] st_ex,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   output logic [5:0]  op_mem,
   output logic        ife_mem,
   output logic [4:0]  Ri_mem,
   output logic [31:0] write_mem,
   output logic        stall_mem,
   output logic        err_mem
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   ms_state_t     state, state_nx;
   logic [CW-1:0] cnt;
   logic [31:0]   rdata_q;
   logic          abort_q;

   logic          ld, stv, mem_op, misalign, start, tmo, capture, bubble;
   logic [31:0]   byte_val, ld_val;

   assign ld       = is_load(op_ex);
   assign stv      = is_store(op_ex);
   assign mem_op   = ld | stv;
   assign misalign = is_word_op(op_ex) && (alu_ex[1:0] != 2'b00);
   assign start    = (state == MS_IDLE) && !abort_q && mem_op && !misalign;
   assign tmo      = (state == MS_WAIT) && !dmem_ack && (cnt == CNT_LAST);
   assign capture  = dmem_ack && (start || (state == MS_WAIT));

   assign dmem_we    = stv;
   assign dmem_addr  = {alu_ex[31:2], 2'b00};
   assign dmem_be    = (op_ex == OP_SB) ? (4'b0001 << alu_ex[1:0]) : 4'hF;
   assign dmem_wdata = (op_ex == OP_SB) ? {4{st_ex[7:0]}} : st_ex;

   load_align u_load_align (
      .rdata  (rdata_q),
      .a      (alu_ex[1:0]),
      .sign   (op_ex == OP_LB),
      .result (byte_val)
   );

   assign ld_val = (op_ex == OP_LW) ? rdata_q : byte_val;

   always_ff @(posedge clk) begin
      if (rst) state <= MS_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         MS_IDLE: if (start) state_nx = dmem_ack ? MS_DONE : MS_WAIT;
         MS_WAIT: begin
            if (dmem_ack)  state_nx = MS_DONE;
            else if (tmo)  state_nx = MS_IDLE;
         end
         MS_DONE: state_nx = MS_IDLE;
         default: state_nx = MS_IDLE;
      endcase
   end

   // The request cycle in IDLE counts toward the timeout, so cnt leaves IDLE at 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         rdata_q <= '0;
         err_mem <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         abort_q <= tmo;
         if (start && !dmem_ack)    cnt <= CW'(1);
         else if (state == MS_WAIT) cnt <= cnt + 1'b1;
         else                       cnt <= '0;
         if (capture) rdata_q <= dmem_rdata;
         if (tmo || ((state == MS_IDLE) && !abort_q && mem_op && misalign))
            err_mem <= 1'b1;
      end
   end

   always_comb begin
      dmem_req  = 1'b0;
      stall_mem = 1'b0;
      bubble    = 1'b0;
      op_mem    = op_ex;
      ife_mem   = ife_ex;
      Ri_mem    = Ri_ex;
      write_mem = alu_ex;
      if (rst) begin
         bubble = 1'b1;
      end else begin
         case (state)
            MS_IDLE: begin
               if (abort_q || mem_op) bubble = 1'b1;
               if (start) begin
                  dmem_req  = 1'b1;
                  stall_mem = 1'b1;
               end
            end
            MS_WAIT: begin
               bubble    = 1'b1;
               dmem_req  = 1'b1;
               stall_mem = 1'b1;
            end
            MS_DONE: begin
               ife_mem   = ife_ex & ld;
               write_mem = ld ? ld_val : alu_ex;
            end
            default: bubble = 1'b1;
         endcase
      end
      if (bubble) begin
         op_mem    = NOP_OP;
         ife_mem   = 1'b0;
         Ri_mem    = 5'd0;
         write_mem = 32'd0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: randomized instruction stream against a reference memory model.
module tb_mem_stage;
   import cpu_defs::*;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  op_ex = OP_NOP;
   logic        ife_ex = 1'b0;
   logic [4:0]  Ri_ex = 5'd0;
   logic [31:0] alu_ex = 32'd0;
   logic [31:0] st_ex = 32'd0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        dmem_ack = 1'b0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic [5:0]  op_mem;
   logic        ife_mem;
   logic [4:0]  Ri_mem;
   logic [31:0] write_mem;
   logic        stall_mem, err_mem;

   mem_stage #(.TIMEOUT(TMO), .NOP_OP(OP_NOP)) dut (
      .clk(clk), .rst(rst), .op_ex(op_ex), .ife_ex(ife_ex), .Ri_ex(Ri_ex),
      .alu_ex(alu_ex), .st_ex(st_ex), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .op_mem(op_mem), .ife_mem(ife_mem), .Ri_mem(Ri_mem),
      .write_mem(write_mem), .stall_mem(stall_mem), .err_mem(err_mem)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic        ife;
      logic [4:0]  ri;
      logic [31:0] wr;
      logic        err;
      int          stalls;
   } ret_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          lat;   // negedges of req before ack; -1 = never ack
   } req_t;

   ret_t        ret_q[$];
   req_t        req_q[$];
   logic [31:0] ref_mem [256];
   logic [31:0] dev_mem [256];
   logic        err_model = 1'b0;
   logic        running = 1'b0;
   int          late_req = 0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: decides what MEM_WB and the memory port must see for one instruction.
   task automatic issue(input logic [5:0] op, input logic ife, input logic [4:0] ri,
                        input logic [31:0] alu, input logic [31:0] st, input int lat);
      ret_t        r;
      req_t        q;
      logic [1:0]  a;
      int          w;
      logic [31:0] word;
      logic [7:0]  b;
      logic        ld, stv, mis;
      bit          done;
      a    = alu[1:0];
      w    = int'(alu[9:2]);
      ld   = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
      stv  = (op == OP_SW) || (op == OP_SB);
      mis  = ((op == OP_LW) || (op == OP_SW)) && (a != 2'b00);
      r    = '{op, ife, ri, alu, err_model, 0};
      if (ld || stv) begin
         if (mis) begin
            r = '{OP_NOP, 1'b0, 5'd0, 32'd0, err_model, 0};
            err_model = 1'b1;
         end else begin
            q.addr  = {alu[31:2], 2'b00};
            q.we    = stv;
            q.be    = (op == OP_SB) ? (4'b0001 << a) : 4'hF;
            q.wdata = (op == OP_SB) ? {4{st[7:0]}} : st;
            q.lat   = lat;
            req_q.push_back(q);
            if (lat < 0) begin
               err_model = 1'b1;
               r = '{OP_NOP, 1'b0, 5'd0, 32'd0, 1'b1, TMO};
            end else begin
               word = ref_mem[w];
               b    = 8'(word >> (8 * int'(a)));
               r.stalls = lat + 1;
               r.ife    = ld ? ife : 1'b0;
               if (op == OP_LW)       r.wr = word;
               else if (op == OP_LB)  r.wr = {{24{b[7]}}, b};
               else if (op == OP_LBU) r.wr = {24'd0, b};
               if (op == OP_SW) ref_mem[w] = st;
               if (op == OP_SB) begin
                  word[8*int'(a) +: 8] = st[7:0];
                  ref_mem[w] = word;
               end
            end
         end
      end
      ret_q.push_back(r);
      op_ex = op; ife_ex = ife; Ri_ex = ri; alu_ex = alu; st_ex = st;
      done = 0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         if (!stall_mem) done = 1;
      end
      if (!done) chk("retire_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every non-stalled cycle of a running stream retires one instruction.
   int   scnt = 0;
   ret_t mr;
   always @(negedge clk) begin
      if (rst || !running) begin
         scnt = 0;
      end else if (stall_mem) begin
         scnt++;
      end else begin
         if (ret_q.size() == 0) begin
            chk("retire_unexpected", 32'd1, 32'd0);
         end else begin
            mr = ret_q.pop_front();
            chk("op_mem", 32'(op_mem), 32'(mr.op));
            chk("ife_mem", 32'(ife_mem), 32'(mr.ife));
            chk("Ri_mem", 32'(Ri_mem), 32'(mr.ri));
            chk("write_mem", write_mem, mr.wr);
            chk("err_mem", 32'(err_mem), 32'(mr.err));
            chk("stall_cycles", scnt, mr.stalls);
            chk("req_at_retire", 32'(dmem_req), 32'd0);
         end
         scnt = 0;
      end
   end

   // Memory responder: checks each new request, acks after its latency, updates its own memory.
   req_t cur;
   bit   in_txn = 0;
   int   wn = 0;
   int   late_done = 0;
   int   idx;
   always @(negedge clk) begin
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      if (late_done != late_req) begin
         late_done  = late_req;
         dmem_ack   = 1'b1;
      end else if (!rst && dmem_req) begin
         if (!in_txn) begin
            in_txn = 1;
            wn     = 0;
            if (req_q.size() == 0) begin
               chk("req_unexpected", 32'd1, 32'd0);
               cur.lat = -1;
            end else begin
               cur = req_q.pop_front();
               chk("dmem_addr", dmem_addr, cur.addr);
               chk("dmem_we", 32'(dmem_we), 32'(cur.we));
               if (cur.we) begin
                  chk("dmem_be", 32'(dmem_be), 32'(cur.be));
                  chk("dmem_wdata", dmem_wdata, cur.wdata);
               end
            end
         end else begin
            wn++;
         end
         if (cur.lat >= 0 && wn == cur.lat) begin
            idx        = int'(dmem_addr[9:2]);
            dmem_ack   = 1'b1;
            dmem_rdata = dev_mem[idx];
            if (dmem_we)
               for (int i = 0; i < 4; i++)
                  if (dmem_be[i]) dev_mem[idx][8*i +: 8] = dmem_wdata[8*i +: 8];
            in_txn = 0;
         end
      end else begin
         in_txn = 0;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  op;
      logic [31:0] alu;
      int          sel, lat;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = $urandom;
         dev_mem[i] = ref_mem[i];
      end
      ref_mem[64] = 32'hDEADBEEF;
      dev_mem[64] = 32'hDEADBEEF;

      // Reset with an aligned load on the inputs: the request must stay suppressed.
      rst = 1'b1; op_ex = OP_LW; ife_ex = 1'b1; Ri_ex = 5'd3; alu_ex = 32'h100;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(stall_mem), 32'd0);
      chk("rst_ife", 32'(ife_mem), 32'd0);
      chk("rst_err", 32'(err_mem), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      running = 1'b1;

      issue(OP_NOP, 1'b1, 5'd5, 32'h1234, 32'd0, 0);
      issue(OP_LW, 1'b1, 5'd8, 32'h100, 32'd0, 3);
      issue(OP_SW, 1'b1, 5'd9, 32'h100, 32'h80FF_FF7F, 1);
      issue(OP_LB, 1'b1, 5'd10, 32'h103, 32'd0, 2);
      issue(OP_LBU, 1'b1, 5'd11, 32'h103, 32'd0, 0);
      issue(OP_SB, 1'b1, 5'd12, 32'h102, 32'hAB, 1);
      issue(OP_LW, 1'b1, 5'd13, 32'h100, 32'd0, 0);
      issue(OP_LW, 1'b1, 5'd14, 32'h101, 32'd0, 0);
      issue(OP_SW, 1'b0, 5'd15, 32'h200, 32'h1111_2222, -1);
      issue(OP_LW, 1'b1, 5'd16, 32'h200, 32'd0, 3);

      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 5);
         lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
         alu = {$urandom} & 32'h0000_03FF;
         case (sel)
            0: begin
               op = 6'($urandom);
               while ((op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
                      (op == OP_SW) || (op == OP_SB))
                  op = 6'($urandom);
               alu = $urandom;
            end
            1: op = OP_LW;
            2: op = OP_LB;
            3: op = OP_LBU;
            4: op = OP_SW;
            default: op = OP_SB;
         endcase
         if (((op == OP_LW) || (op == OP_SW)) && ($urandom_range(0, 7) != 0))
            alu[1:0] = 2'b00;
         issue(op, 1'($urandom), 5'($urandom), alu, $urandom, lat);
      end

      // Reset in the middle of an outstanding access, then a stray ack.
      running = 1'b0;
      req_q.push_back('{32'h100, 1'b0, 4'hF, 32'd0, -1});
      op_ex = OP_LW; ife_ex = 1'b1; Ri_ex = 5'd7; alu_ex = 32'h100;
      repeat (2) @(posedge clk);
      #1;
      chk("wait_stall", 32'(stall_mem), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_wait_req", 32'(dmem_req), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0; op_ex = OP_NOP; ife_ex = 1'b0; alu_ex = 32'h55; Ri_ex = 5'd0;
      late_req++;
      @(negedge clk);
      chk("post_rst_req", 32'(dmem_req), 32'd0);
      chk("post_rst_stall", 32'(stall_mem), 32'd0);
      chk("post_rst_err", 32'(err_mem), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("late_ack_stall", 32'(stall_mem), 32'd0);
      chk("late_ack_write", write_mem, 32'h55);
      @(posedge clk);
      #1;
      err_model = 1'b0;
      running   = 1'b1;
      issue(OP_LW, 1'b1, 5'd20, 32'h100, 32'd0, 1);
      running = 1'b0;
      chk("ret_q_empty", 32'(ret_q.size()), 32'd0);
      chk("req_q_empty", 32'(req_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
